// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM, returning tagged words on a registered bus.
// Optional macro SPRITE_KEY_EN adds a registered transparency flag (rdata_opaque).
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 1,
  parameter logic [DATA_W-1:0] KEY_COLOR = 16'hF81F
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic                          rvalid,
  output logic [$clog2(NUM_REQ)-1:0]    rid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rdata_opaque
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Handshake: req/req_addr stay stable until gnt is seen; the return bus has no ready.
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   found;
  logic [ID_W-1:0]        win_idx;
  logic [ROM_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]        tag_id_q [ROM_LATENCY];
  logic [ID_W-1:0]        tag_id_d [ROM_LATENCY];
  logic                   rvalid_q, rvalid_d;
  logic [ID_W-1:0]        rid_q, rid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    gnt      = '0;
    rom_addr = '0;
    ptr_d    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
    if (reset) found = 1'b0;
    if (found) begin
      gnt[win_idx] = 1'b1;
      rom_addr     = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      ptr_d        = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + ID_W'(1);
    end
  end

  // Tag stages track the ROM's own latency so the last stage lines up with rom_data.
  always_comb begin
    tag_valid_d[0] = found;
    tag_id_d[0]    = win_idx;
    for (int s = 1; s < ROM_LATENCY; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_id_d[s]    = tag_id_q[s-1];
    end
    rvalid_d = tag_valid_q[ROM_LATENCY-1];
    rid_d    = rvalid_d ? tag_id_q[ROM_LATENCY-1] : rid_q;
    rdata_d  = rvalid_d ? rom_data : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      tag_valid_q <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) tag_id_q[s] <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign rdata  = rdata_q;

`ifdef SPRITE_KEY_EN
  logic opaque_q, opaque_d;

  always_comb begin
    opaque_d = rvalid_d ? (rom_data != KEY_COLOR) : opaque_q;
  end

  always_ff @(posedge clk) begin
    if (reset) opaque_q <= 1'b0;
    else       opaque_q <= opaque_d;
  end

  assign rdata_opaque = opaque_q;
`else
  assign rdata_opaque = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios then random traffic, checked cycle by cycle
// against a grant/return model built from round-robin rules and a due-cycle return queue.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic            rvalid;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic            rdata_opaque;

  sprite_rom_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1), .KEY_COLOR(16'hF81F)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_data(rom_data), .rvalid(rvalid), .rid(rid),
    .rdata(rdata), .rdata_opaque(rdata_opaque)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 12'h020) return 16'hF81F;
    return {4'h0, a} ^ 16'hA5A5;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: round-robin pointer, returns due by cycle {due[33:18], id[17:16], data[15:0]}.
  int              cyc;
  int              m_ptr;
  logic [33:0]     exp_q[$];
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic            m_opq;
  logic [N-1:0]    last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int            w;
    logic [N-1:0]  exp_gnt;
    logic [AW-1:0] exp_addr;
    logic          exp_rv;
    logic [33:0]   e;
    @(negedge clk);
    w = -1;
    if (!reset)
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    exp_gnt  = (w >= 0) ? N'(1) << w : '0;
    exp_addr = (w >= 0) ? req_addr[w*AW +: AW] : '0;
    chk("gnt", gnt, exp_gnt);
    chk("rom_addr", rom_addr, exp_addr);
    exp_rv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0][33:18] == 16'(cyc)) begin
      e       = exp_q.pop_front();
      exp_rv  = 1'b1;
      m_rid   = e[17:16];
      m_rdata = e[15:0];
`ifdef SPRITE_KEY_EN
      m_opq   = (e[15:0] != 16'hF81F);
`endif
    end
    chk("rvalid", rvalid, exp_rv);
    chk("rid", rid, m_rid);
    chk("rdata", rdata, m_rdata);
    chk("rdata_opaque", rdata_opaque, m_opq);
    last_gnt = gnt;
    if (reset) begin
      exp_q.delete();
      m_ptr = 0; m_rid = '0; m_rdata = '0; m_opq = 1'b0;
    end else if (w >= 0) begin
      exp_q.push_back({16'(cyc + 2), IW'(w), rom_fn(exp_addr)});
      m_ptr = (w + 1) % N;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_addr = '0;
    cyc = 0; m_ptr = 0; m_rid = '0; m_rdata = '0; m_opq = 1'b0; last_gnt = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step();
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_rdata", rdata, 16'h0);
    reset = 1'b0;

    // 1. Single request from requester 2
    req = 4'b0100; req_addr[2*AW +: AW] = 12'h010;
    step();
    chk("t1_gnt", last_gnt, 4'b0100);
    req = '0;
    step();
    chk("t1_rvalid", rvalid, 1'b1);
    chk("t1_rid", rid, 2'd2);
    chk("t1_rdata", rdata, 16'hA5B5);

    // 2. Saturation from reset
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(12'h100 + i);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_gnt_order", last_gnt, 4'b0001 << (k % 4));
    end
    chk("t2_rvalid_cont", rvalid, 1'b1);

    // 3. Rotation
    req = 4'b0010; step(); chk("t3_gnt1", last_gnt, 4'b0010);
    req = 4'b0101; step(); chk("t3_gnt2", last_gnt, 4'b0100);
    step();                chk("t3_gnt0", last_gnt, 4'b0001);

    // 4. Reset with reads in flight
    req = 4'b1111; step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("t4_no_rvalid", rvalid, 1'b0);
    req = 4'b1010; step(); chk("t4_gnt", last_gnt, 4'b0010);

    // 5. Idle, pointer must hold (last grant was to 1)
    req = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_idle_gnt", last_gnt, 4'b0000);
    end
    req = 4'b1111; step(); chk("t5_ptr_kept", last_gnt, 4'b0100);

    // 6. Key colour
    req = '0; step(); step();
    req = 4'b0001; req_addr[0 +: AW] = 12'h020; step(); req = '0; step();
    chk("t6_key_rdata", rdata, 16'hF81F);
    chk("t6_key_opaque", rdata_opaque, 1'b0);
    req = 4'b0001; req_addr[0 +: AW] = 12'h021; step(); req = '0; step();
`ifdef SPRITE_KEY_EN
    chk("t6_nonkey_opaque", rdata_opaque, 1'b1);
`else
    chk("t6_nonkey_opaque", rdata_opaque, 1'b0);
`endif

    // Random traffic: requesters hold addr until granted, occasional reset
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 99) < 60);
          if ($urandom_range(0, 3) == 0) req_addr[i*AW +: AW] = AW'(12'h020 + $urandom_range(0, 1));
          else                           req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      step();
    end
    reset = 1'b0; req = '0;
    repeat (4) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
